// File: rtl/project_pwm_compare_deadtime_if.sv
// ----------------------------------------------------------------------------
// project_pwm_compare_deadtime_if
//   Bundle of counter, duty, dead-time and output signals for the PWM compare
//   stage. The compare stage uses the slave modport; whatever drives the
//   counter and configuration uses the master modport.
//   i_en, i_mode, i_period, i_period_cnt, i_period_next : master counter view
//   i_duty, i_duty_wr                                    : shadow duty write
//   i_deadtime, i_pol_h, i_pol_l, i_out_en               : output shaping
//   o_pwm_h, o_pwm_l, o_duty_active, o_update            : results
// ----------------------------------------------------------------------------
interface project_pwm_compare_deadtime_if #(
    parameter int DT_W = 8
);
    logic            i_en;
    logic [1:0]      i_mode;
    logic [15:0]     i_period;
    logic [15:0]     i_period_cnt;
    logic [15:0]     i_period_next;
    logic [15:0]     i_duty;
    logic            i_duty_wr;
    logic [DT_W-1:0] i_deadtime;
    logic            i_pol_h;
    logic            i_pol_l;
    logic            i_out_en;
    logic            o_pwm_h;
    logic            o_pwm_l;
    logic [15:0]     o_duty_active;
    logic            o_update;

    modport master (
        output i_en, i_mode, i_period, i_period_cnt, i_period_next,
        output i_duty, i_duty_wr, i_deadtime, i_pol_h, i_pol_l, i_out_en,
        input  o_pwm_h, o_pwm_l, o_duty_active, o_update
    );

    modport slave (
        input  i_en, i_mode, i_period, i_period_cnt, i_period_next,
        input  i_duty, i_duty_wr, i_deadtime, i_pol_h, i_pol_l, i_out_en,
        output o_pwm_h, o_pwm_l, o_duty_active, o_update
    );
endinterface

// File: rtl/project_pwm_compare_deadtime.sv
// ----------------------------------------------------------------------------
// project_pwm_compare_deadtime
//   Compares the master period counter against a double-buffered duty value
//   and drives a complementary high/low PWM pair with programmable dead time
//   on every edge. New duty values only take effect at a period boundary.
//   i_clk      : clock
//   i_reset_n  : synchronous reset, active low
//   pwm        : slave view of the PWM bus (counter inputs, duty write,
//                dead time, polarity, output enable; registered pins,
//                active duty and load pulse out)
// ----------------------------------------------------------------------------
module project_pwm_compare_deadtime #(
    parameter int DT_W = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    project_pwm_compare_deadtime_if.slave pwm
);

    localparam logic [1:0]      MODE_OFF  = 2'b00;
    localparam logic [1:0]      MODE_DOWN = 2'b10;
    localparam logic [DT_W-1:0] DT_ONE    = {{(DT_W-1){1'b0}}, 1'b1};
    localparam logic [DT_W-1:0] DT_ZERO   = '0;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_DT_RISE,
        ST_HIGH,
        ST_DT_FALL
    } state_t;

    logic [15:0]     shadow_q;
    logic [15:0]     active_q;
    logic [15:0]     duty_next;
    logic            pending_q;
    logic            boundary;
    logic            do_load;
    logic            raw_cmp_q;
    logic            update_q;
    state_t          state_q;
    state_t          state_d;
    logic [DT_W-1:0] dt_cnt_q;
    logic [DT_W-1:0] dt_cnt_d;
    logic            h_d;
    logic            l_d;
    logic            pin_h_d;
    logic            pin_l_d;
    logic            pin_h_q;
    logic            pin_l_q;

    // Period boundary as seen from the counter's register/next pair: the edge
    // on which the counter is about to wrap.
    always_comb begin
        boundary = 1'b0;
        case (pwm.i_mode)
            MODE_OFF:  boundary = 1'b1;
            MODE_DOWN: boundary = (pwm.i_period_next == pwm.i_period) &&
                                  (pwm.i_period_cnt  != pwm.i_period);
            default:   boundary = (pwm.i_period_next == 16'd0) &&
                                  (pwm.i_period_cnt  != 16'd0);
        endcase
    end

    // A write landing on the boundary bypasses the shadow and loads directly.
    assign do_load   = pwm.i_en && boundary && (pwm.i_duty_wr || pending_q);
    assign duty_next = do_load ? (pwm.i_duty_wr ? pwm.i_duty : shadow_q) : active_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
            raw_cmp_q <= 1'b0;
        end else begin
            if (pwm.i_duty_wr)
                shadow_q <= pwm.i_duty;
            if (do_load)
                pending_q <= 1'b0;
            else if (pwm.i_duty_wr)
                pending_q <= 1'b1;
            active_q <= duty_next;
            update_q <= do_load;
            // Compare against the duty that becomes active on this same edge,
            // so the first cycle of a new period already uses the new duty.
            if (pwm.i_en)
                raw_cmp_q <= (pwm.i_mode == MODE_OFF) ? 1'b0
                                                      : (pwm.i_period_next < duty_next);
        end
    end

    // Dead-time FSM: state register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= ST_LOW;
            dt_cnt_q <= '0;
            pin_h_q  <= 1'b0;
            pin_l_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
            pin_h_q  <= pin_h_d;
            pin_l_q  <= pin_l_d;
        end
    end

    // Dead-time FSM: next state. Dead time is sampled only on entry to a
    // dead-time state; the counter then runs down D-1..0, giving D dead cycles.
    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        case (state_q)
            ST_LOW: begin
                if (raw_cmp_q) begin
                    dt_cnt_d = pwm.i_deadtime - DT_ONE;
                    state_d  = (pwm.i_deadtime == DT_ZERO) ? ST_HIGH : ST_DT_RISE;
                end
            end
            ST_DT_RISE: begin
                if (!raw_cmp_q)
                    state_d = ST_LOW;
                else if (dt_cnt_q == DT_ZERO)
                    state_d = ST_HIGH;
                else
                    dt_cnt_d = dt_cnt_q - DT_ONE;
            end
            ST_HIGH: begin
                if (!raw_cmp_q) begin
                    dt_cnt_d = pwm.i_deadtime - DT_ONE;
                    state_d  = (pwm.i_deadtime == DT_ZERO) ? ST_LOW : ST_DT_FALL;
                end
            end
            ST_DT_FALL: begin
                if (raw_cmp_q)
                    state_d = ST_HIGH;
                else if (dt_cnt_q == DT_ZERO)
                    state_d = ST_LOW;
                else
                    dt_cnt_d = dt_cnt_q - DT_ONE;
            end
            default: state_d = ST_LOW;
        endcase
    end

    // Dead-time FSM: outputs, decoded from the next state so the registered
    // pins move on the same edge as the state.
    always_comb begin
        h_d     = (state_d == ST_HIGH);
        l_d     = (state_d == ST_LOW);
        pin_h_d = pwm.i_out_en ? (h_d ^ pwm.i_pol_h) : pwm.i_pol_h;
        pin_l_d = pwm.i_out_en ? (l_d ^ pwm.i_pol_l) : pwm.i_pol_l;
    end

    assign pwm.o_pwm_h       = pin_h_q;
    assign pwm.o_pwm_l       = pin_l_q;
    assign pwm.o_duty_active = active_q;
    assign pwm.o_update      = update_q;

endmodule

// File: tb/tb_project_pwm_compare_deadtime.sv
// ----------------------------------------------------------------------------
// tb_project_pwm_compare_deadtime
//   Directed bench: the bench itself plays the master counter, steps through
//   UP / DOWN / UP_DOWN scenarios and compares pin patterns (indexed by the
//   counter value seen after each edge) with hand-derived constants.
// ----------------------------------------------------------------------------
module tb_project_pwm_compare_deadtime;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    project_pwm_compare_deadtime_if #(.DT_W(8)) bus ();

    project_pwm_compare_deadtime #(.DT_W(8)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .pwm       (bus)
    );

    int          total   = 0;
    int          passed  = 0;
    int          overlap = 0;
    logic [15:0] cnt, nxt;
    logic        up;
    logic [9:0]  hp, lp;
    int          hsum, lsum, dsum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: the DUT samples the old counter pair at the edge, then the
    // bench counter advances and the outputs are observed 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.i_en) begin
            cnt = nxt;
            case (bus.i_mode)
                2'b01: nxt = (cnt >= bus.i_period) ? 16'd0 : cnt + 16'd1;
                2'b10: nxt = (cnt == 16'd0) ? bus.i_period : cnt - 16'd1;
                2'b11: begin
                    if (up) begin
                        if (cnt >= bus.i_period) begin up = 1'b0; nxt = cnt - 16'd1; end
                        else nxt = cnt + 16'd1;
                    end else begin
                        if (cnt == 16'd0) begin up = 1'b1; nxt = cnt + 16'd1; end
                        else nxt = cnt - 16'd1;
                    end
                end
                default: nxt = cnt;
            endcase
        end
        bus.i_period_cnt  = cnt;
        bus.i_period_next = nxt;
        if (!bus.i_pol_h && !bus.i_pol_l && bus.o_pwm_h && bus.o_pwm_l)
            overlap++;
    endtask

    task automatic set_cnt(input logic [15:0] c, input logic [15:0] n, input logic d);
        cnt = c; nxt = n; up = d;
        bus.i_period_cnt  = cnt;
        bus.i_period_next = nxt;
    endtask

    task automatic wr_duty(input logic [15:0] v);
        bus.i_duty    = v;
        bus.i_duty_wr = 1'b1;
        tick();
        bus.i_duty_wr = 1'b0;
    endtask

    task automatic wait_cnt(input logic [15:0] v);
        int n = 0;
        while (cnt != v && n < 40) begin tick(); n++; end
        if (cnt != v) begin
            total++;
            $display("FAIL wait_cnt: counter at %0d, wanted %0d within 40 cycles", cnt, v);
        end
    endtask

    task automatic capture(output logic [9:0] h, output logic [9:0] l);
        h = '0; l = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            h[cnt[3:0]] = bus.o_pwm_h;
            l[cnt[3:0]] = bus.o_pwm_l;
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.i_en          = 1'b0;
        bus.i_mode        = 2'b01;
        bus.i_period      = 16'd9;
        bus.i_duty        = 16'd0;
        bus.i_duty_wr     = 1'b0;
        bus.i_deadtime    = 8'd0;
        bus.i_pol_h       = 1'b0;
        bus.i_pol_l       = 1'b0;
        bus.i_out_en      = 1'b1;
        set_cnt(16'd0, 16'd1, 1'b1);

        // Reset state
        tick(); tick();
        chk("rst_pwm_h", bus.o_pwm_h, 0);
        chk("rst_pwm_l", bus.o_pwm_l, 0);
        chk("rst_update", bus.o_update, 0);
        chk("rst_duty_active", bus.o_duty_active, 0);

        // 1: UP, period 9, duty 4, no dead time
        rst_n    = 1'b1;
        bus.i_en = 1'b1;
        wr_duty(16'd4);
        repeat (25) tick();
        capture(hp, lp);
        chk("t1_h_pattern", hp, 10'h01E);
        chk("t1_l_pattern", lp, 10'h3E1);

        // 2: dead time 2
        bus.i_deadtime = 8'd2;
        repeat (20) tick();
        capture(hp, lp);
        chk("t2_h_pattern", hp, 10'h018);
        chk("t2_l_pattern", lp, 10'h381);

        // 3: duty 7 written mid-period takes effect only at the wrap
        bus.i_deadtime = 8'd0;
        repeat (20) tick();
        wait_cnt(16'd5);
        wr_duty(16'd7);
        chk("t3_active_before", bus.o_duty_active, 4);
        chk("t3_update_early", bus.o_update, 0);
        hsum = bus.o_pwm_h;
        repeat (3) begin tick(); hsum += bus.o_pwm_h; end
        chk("t3_no_partial", hsum, 0);
        chk("t3_update_cnt9", bus.o_update, 0);
        tick();
        chk("t3_update_wrap", bus.o_update, 1);
        chk("t3_active_after", bus.o_duty_active, 7);
        tick();
        chk("t3_update_1cyc", bus.o_update, 0);
        capture(hp, lp);
        chk("t3_h_pattern", hp, 10'h0FE);

        // 4: 0% and 100% duty
        wr_duty(16'd0);
        repeat (20) tick();
        capture(hp, lp);
        chk("t4_h_duty0", hp, 10'h000);
        chk("t4_l_duty0", lp, 10'h3FF);
        bus.i_deadtime = 8'd2;
        wr_duty(16'd10);
        repeat (20) tick();
        capture(hp, lp);
        chk("t4_h_duty10", hp, 10'h3FF);
        chk("t4_l_duty10", lp, 10'h000);

        // DOWN mode: load point is the 0 -> period reload
        bus.i_mode = 2'b10;
        set_cnt(16'd9, 16'd8, 1'b0);
        wait_cnt(16'd5);
        wr_duty(16'd6);
        wait_cnt(16'd0);
        chk("dn_active_before", bus.o_duty_active, 10);
        chk("dn_update_early", bus.o_update, 0);
        tick();
        chk("dn_update_reload", bus.o_update, 1);
        chk("dn_active_after", bus.o_duty_active, 6);

        // 5: UP_DOWN, period 8, duty 3, dead time 1 (16-cycle period)
        bus.i_mode     = 2'b11;
        bus.i_period   = 16'd8;
        bus.i_deadtime = 8'd1;
        set_cnt(16'd0, 16'd1, 1'b1);
        wr_duty(16'd3);
        repeat (40) tick();
        hsum = 0; lsum = 0; dsum = 0;
        repeat (16) begin
            tick();
            hsum += bus.o_pwm_h;
            lsum += bus.o_pwm_l;
            dsum += (!bus.o_pwm_h && !bus.o_pwm_l) ? 1 : 0;
        end
        chk("t5_h_cycles", hsum, 4);
        chk("t5_l_cycles", lsum, 10);
        chk("t5_dead_cycles", dsum, 2);

        // 6: reset mid-run with outputs disabled and active-low high side
        bus.i_mode   = 2'b01;
        bus.i_period = 16'd9;
        set_cnt(16'd0, 16'd1, 1'b1);
        bus.i_out_en = 1'b0;
        bus.i_pol_h  = 1'b1;
        tick();
        chk("t6_h_disabled", bus.o_pwm_h, 1);
        chk("t6_l_disabled", bus.o_pwm_l, 0);
        repeat (4) tick();
        rst_n         = 1'b0;
        bus.i_duty    = 16'd123;
        bus.i_duty_wr = 1'b1;
        tick();
        chk("t6_rst_h", bus.o_pwm_h, 0);
        chk("t6_rst_l", bus.o_pwm_l, 0);
        chk("t6_rst_update", bus.o_update, 0);
        chk("t6_rst_active", bus.o_duty_active, 0);
        rst_n         = 1'b1;
        bus.i_duty_wr = 1'b0;
        tick();
        chk("t6_post_h", bus.o_pwm_h, 1);
        chk("t6_post_l", bus.o_pwm_l, 0);
        chk("t6_post_active", bus.o_duty_active, 0);
        bus.i_out_en = 1'b1;
        tick();
        chk("t6_en_h", bus.o_pwm_h, 1);
        chk("t6_en_l", bus.o_pwm_l, 1);

        chk("no_overlap", overlap, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
